// File: rtl/id_queue_decode.sv
// Instruction queue between fetch and execute, with a combinational RISC-V decoder
// on the head entry and a saturating count of illegal instructions retired.
module id_queue_decode #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int EN_M  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic [XLEN-1:0]        out_pc,
  output logic [4:0]             alu_ct,
  output logic [2:0]             extop,
  output logic                   reg_wr,
  output logic                   alu_asr,
  output logic [1:0]             alu_bsr,
  output logic [2:0]             branch,
  output logic                   mem_wr,
  output logic [2:0]             mem_op,
  output logic [1:0]             reg_src,
  output logic                   is_truncate,
  output logic                   is_sext,
  output logic                   intr_en,
  output logic                   illegal,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            illegal_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam bit RV32 = (XLEN == 32);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // ---------------------------------------------------------------- queue
  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic [15:0]   illegal_cnt_reg;
  logic          push, pop;

  assign in_ready    = (count_reg != FULL);
  assign out_valid   = (count_reg != '0);
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign count       = count_reg;
  assign illegal_cnt = illegal_cnt_reg;
  assign out_inst    = inst_mem[rd_ptr_reg];
  assign out_pc      = pc_mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage is deliberately unreset; a write during flush lands in a slot that is
  // immediately considered empty again.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_reg] <= in_inst;
      pc_mem[wr_ptr_reg]   <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      illegal_cnt_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (pop && illegal && (illegal_cnt_reg != 16'hFFFF))
        illegal_cnt_reg <= illegal_cnt_reg + 16'd1;
    end
  end

  // --------------------------------------------------------------- decode
  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic       m_op, word_op, known, rv32_bad, m_bad;
  logic [4:0] alu_generic;

  logic [4:0] alu_ct_dec;
  logic [2:0] extop_dec, branch_dec, mem_op_dec;
  logic       reg_wr_dec, alu_asr_dec, mem_wr_dec, word_dec, intr_en_dec;
  logic [1:0] alu_bsr_dec, reg_src_dec;

  assign opcode  = out_inst[6:0];
  assign func3   = out_inst[14:12];
  assign func7   = out_inst[31:25];
  assign word_op = (opcode == OPC_OP_IMM32) || (opcode == OPC_OP32);
  assign m_op    = ((opcode == OPC_OP) || (opcode == OPC_OP32)) && (func7 == 7'b0000001);

  // Shared ALU selection for the register/immediate arithmetic group and SYSTEM.
  assign alu_generic = (func3 == 3'b011) ? 5'b01010
                     : {1'b0, func7[5] & ((|func3) | opcode[5]), func3};

  always_comb begin
    alu_ct_dec  = '0;
    extop_dec   = '0;
    alu_asr_dec = 1'b0;
    alu_bsr_dec = '0;
    branch_dec  = 3'b010;
    mem_wr_dec  = 1'b0;
    mem_op_dec  = '0;
    reg_src_dec = '0;
    word_dec    = 1'b0;
    intr_en_dec = 1'b0;
    known       = 1'b1;
    case (opcode)
      OPC_LOAD: begin
        extop_dec   = 3'd2;
        alu_asr_dec = 1'b1;
        reg_src_dec = 2'd1;
        case (func3)
          3'b000:  mem_op_dec = 3'b111;
          3'b001:  mem_op_dec = 3'b110;
          3'b010:  mem_op_dec = 3'b101;
          3'b011:  mem_op_dec = 3'b100;
          3'b100:  mem_op_dec = 3'b011;
          3'b101:  mem_op_dec = 3'b010;
          3'b110:  mem_op_dec = 3'b001;
          default: mem_op_dec = 3'b000;
        endcase
      end
      OPC_STORE: begin
        extop_dec   = 3'd3;
        alu_asr_dec = 1'b1;
        mem_wr_dec  = 1'b1;
        case (func3)
          3'b000:  mem_op_dec = 3'b011;
          3'b001:  mem_op_dec = 3'b010;
          3'b010:  mem_op_dec = 3'b001;
          3'b011:  mem_op_dec = 3'b100;
          default: mem_op_dec = 3'b000;
        endcase
      end
      OPC_OP_IMM, OPC_OP_IMM32: begin
        extop_dec   = 3'd2;
        alu_asr_dec = 1'b1;
        alu_ct_dec  = alu_generic;
        word_dec    = (opcode == OPC_OP_IMM32);
      end
      OPC_OP, OPC_OP32: begin
        extop_dec   = 3'd1;
        alu_asr_dec = 1'b1;
        alu_bsr_dec = 2'd1;
        alu_ct_dec  = m_op ? {1'b1, func3[0], func3} : alu_generic;
        word_dec    = (opcode == OPC_OP32);
      end
      OPC_LUI: begin
        extop_dec  = 3'd5;
        alu_ct_dec = 5'b00011;
      end
      OPC_AUIPC: extop_dec = 3'd5;
      OPC_BRANCH: begin
        extop_dec   = 3'd4;
        alu_asr_dec = 1'b1;
        alu_bsr_dec = 2'd1;
        alu_ct_dec  = {1'b0, func3[1], 3'b010};
        branch_dec  = func3 & 3'b101;
      end
      OPC_JAL: begin
        extop_dec   = 3'd6;
        alu_bsr_dec = 2'd2;
        branch_dec  = 3'b110;
      end
      OPC_JALR: begin
        extop_dec   = 3'd2;
        alu_bsr_dec = 2'd2;
        branch_dec  = 3'b111;
      end
      OPC_SYSTEM: begin
        extop_dec   = 3'd2;
        alu_asr_dec = 1'b1;
        reg_src_dec = 2'd2;
        intr_en_dec = 1'b1;
        alu_ct_dec  = alu_generic;
      end
      default: known = 1'b0;
    endcase
    reg_wr_dec = (extop_dec == 3'd1) || (extop_dec == 3'd2) ||
                 (extop_dec == 3'd5) || (extop_dec == 3'd6);
  end

  // Doubleword and word-op encodings do not exist on a 32-bit datapath.
  assign rv32_bad = RV32 && (word_op ||
                    ((opcode == OPC_LOAD)  && ((func3 == 3'b011) || (func3 == 3'b110))) ||
                    ((opcode == OPC_STORE) && (func3 == 3'b011)));
  assign m_bad    = (EN_M == 0) && m_op;
  assign illegal  = !known || (out_inst[1:0] != 2'b11) || rv32_bad || m_bad;

  assign alu_ct      = illegal ? 5'b0   : alu_ct_dec;
  assign extop       = illegal ? 3'b0   : extop_dec;
  assign reg_wr      = illegal ? 1'b0   : reg_wr_dec;
  assign alu_asr     = illegal ? 1'b0   : alu_asr_dec;
  assign alu_bsr     = illegal ? 2'b0   : alu_bsr_dec;
  assign branch      = illegal ? 3'b010 : branch_dec;
  assign mem_wr      = illegal ? 1'b0   : mem_wr_dec;
  assign mem_op      = illegal ? 3'b0   : mem_op_dec;
  assign reg_src     = illegal ? 2'b0   : reg_src_dec;
  assign is_truncate = illegal ? 1'b0   : word_dec;
  assign is_sext     = illegal ? 1'b0   : word_dec;
  assign intr_en     = illegal ? 1'b0   : intr_en_dec;

endmodule

// File: tb/tb_id_queue_decode.sv
// Bench for id_queue_decode: decode vector table, queue corner sequences,
// and randomized traffic against a queue-plus-decoder reference model.
module tb_id_queue_decode;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 64-bit, M enabled, depth 4
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_inst, out_inst;
  logic [63:0] in_pc, out_pc;
  logic [4:0]  alu_ct;
  logic [2:0]  extop, branch, mem_op;
  logic        reg_wr, alu_asr, mem_wr, is_truncate, is_sext, intr_en, illegal;
  logic [1:0]  alu_bsr, reg_src;
  logic [2:0]  count;
  logic [15:0] illegal_cnt;

  // 32-bit, M disabled, depth 2
  logic        in_valid_b, in_ready_b, flush_b, out_valid_b, out_ready_b;
  logic [31:0] in_inst_b, out_inst_b, in_pc_b, out_pc_b;
  logic [4:0]  alu_ct_b;
  logic [2:0]  extop_b, branch_b, mem_op_b;
  logic        reg_wr_b, alu_asr_b, mem_wr_b, is_truncate_b, is_sext_b, intr_en_b, illegal_b;
  logic [1:0]  alu_bsr_b, reg_src_b;
  logic [1:0]  count_b;
  logic [15:0] illegal_cnt_b;

  id_queue_decode #(.XLEN(64), .DEPTH(4), .EN_M(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .alu_ct(alu_ct), .extop(extop), .reg_wr(reg_wr), .alu_asr(alu_asr),
    .alu_bsr(alu_bsr), .branch(branch), .mem_wr(mem_wr), .mem_op(mem_op),
    .reg_src(reg_src), .is_truncate(is_truncate), .is_sext(is_sext),
    .intr_en(intr_en), .illegal(illegal), .count(count), .illegal_cnt(illegal_cnt)
  );

  id_queue_decode #(.XLEN(32), .DEPTH(2), .EN_M(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_inst(in_inst_b), .in_pc(in_pc_b), .flush(flush_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_inst(out_inst_b), .out_pc(out_pc_b),
    .alu_ct(alu_ct_b), .extop(extop_b), .reg_wr(reg_wr_b), .alu_asr(alu_asr_b),
    .alu_bsr(alu_bsr_b), .branch(branch_b), .mem_wr(mem_wr_b), .mem_op(mem_op_b),
    .reg_src(reg_src_b), .is_truncate(is_truncate_b), .is_sext(is_sext_b),
    .intr_en(intr_en_b), .illegal(illegal_b), .count(count_b), .illegal_cnt(illegal_cnt_b)
  );

  logic [24:0] ctl;
  assign ctl = {alu_ct, extop, reg_wr, alu_asr, alu_bsr, branch, mem_wr, mem_op,
                reg_src, is_truncate, is_sext, intr_en, illegal};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [24:0] pack(input int alu, input int ext, input int rw, input int asr,
                                       input int bsr, input int br, input int mw, input int mop,
                                       input int rs, input int tr, input int sx, input int ie,
                                       input int il);
    return {5'(alu), 3'(ext), 1'(rw), 1'(asr), 2'(bsr), 3'(br), 1'(mw), 3'(mop),
            2'(rs), 1'(tr), 1'(sx), 1'(ie), 1'(il)};
  endfunction

  // Reference decoder: classify by instruction format, then apply the field rules.
  function automatic logic [24:0] model_ctl(input logic [31:0] ins, input int xlen, input int en_m);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    string fmt;
    bit is_bad, word, mext;
    int ext, rw, asr, bsr, br, alu, mop, rs, size;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (op)
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: fmt = "I";
      7'h33, 7'h3B:                      fmt = "R";
      7'h23:                             fmt = "S";
      7'h63:                             fmt = "B";
      7'h37, 7'h17:                      fmt = "U";
      7'h6F:                             fmt = "J";
      default:                           fmt = "";
    endcase
    word   = (op == 7'h1B) || (op == 7'h3B);
    mext   = (fmt == "R") && (f7 == 7'd1);
    is_bad = (fmt == "") || (ins[1:0] != 2'b11);
    if (xlen == 32 && (word || (op == 7'h03 && (f3 == 3 || f3 == 6)) || (op == 7'h23 && f3 == 3)))
      is_bad = 1;
    if (mext && en_m == 0) is_bad = 1;
    if (is_bad) return pack(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1);
    case (fmt)
      "I": ext = 2;
      "R": ext = 1;
      "S": ext = 3;
      "B": ext = 4;
      "U": ext = 5;
      default: ext = 6;
    endcase
    rw  = (fmt != "S" && fmt != "B") ? 1 : 0;
    asr = (fmt == "R" || fmt == "S" || fmt == "B" || (fmt == "I" && op != 7'h67)) ? 1 : 0;
    bsr = (op == 7'h6F || op == 7'h67) ? 2 : (fmt == "R" || fmt == "B") ? 1 : 0;
    br  = (op == 7'h63) ? int'(f3 & 3'b101) : (op == 7'h6F) ? 6 : (op == 7'h67) ? 7 : 2;
    if (op == 7'h17 || op == 7'h03 || op == 7'h23 || op == 7'h6F || op == 7'h67) alu = 0;
    else if (op == 7'h63) alu = 2 + 8 * int'(f3[1]);
    else if (op == 7'h37) alu = 3;
    else if (mext)        alu = 16 + 8 * int'(f3[0]) + int'(f3);
    else if (f3 == 3)     alu = 10;
    else                  alu = 8 * int'(f7[5] & (f3 != 0 || op[5])) + int'(f3);
    size = int'(f3[1:0]);
    mop  = 0;
    if (op == 7'h03)      mop = f3[2] ? ((size == 3) ? 0 : 3 - size) : 7 - size;
    else if (op == 7'h23) mop = f3[2] ? 0 : ((size == 3) ? 4 : 3 - size);
    rs = (op == 7'h03) ? 1 : (op == 7'h73) ? 2 : 0;
    return pack(alu, ext, rw, asr, bsr, br, (op == 7'h23) ? 1 : 0, mop, rs,
                word ? 1 : 0, word ? 1 : 0, (op == 7'h73) ? 1 : 0, 0);
  endfunction

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [24:0] expct;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } entry_t;

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [12];
    logic [31:0] ins;
    int sel;
    ops = '{7'h03, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};
    ins = $urandom;
    sel = $urandom_range(0, 13);
    if (sel < 12) ins[6:0] = ops[sel];
    else if (sel == 12) ins[6:0] = 7'($urandom);
    if (ins[6:0] == 7'h33 || ins[6:0] == 7'h3B) begin
      case ($urandom_range(0, 3))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h01;
        2: ins[31:25] = 7'h20;
        default: ;
      endcase
    end
    return ins;
  endfunction

  vec_t   tbl[$];
  entry_t mq[$];
  int     n_ill;
  int     m_ill;

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_inst = 0; in_pc = 0; flush = 0; out_ready = 0;
    in_valid_b = 0; in_inst_b = 0; in_pc_b = 0; flush_b = 0; out_ready_b = 0;

    tbl.push_back('{"addi",  32'h00500093, pack(0, 2, 1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"sd",    32'h00113023, pack(0, 3, 0, 1, 0, 2, 1, 4, 0, 0, 0, 0, 0)});
    tbl.push_back('{"mul",   32'h022081B3, pack(16, 1, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"sub",   32'h402081B3, pack(8, 1, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"lui",   32'h123452B7, pack(3, 5, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"auipc", 32'h00000517, pack(0, 5, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"jal",   32'h000000EF, pack(0, 6, 1, 0, 2, 6, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"jalr",  32'h00008067, pack(0, 2, 1, 0, 2, 7, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"bne",   32'h00209063, pack(2, 4, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"bltu",  32'h0020E063, pack(10, 4, 0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"lw",    32'h0000A283, pack(0, 2, 1, 1, 0, 2, 0, 5, 1, 0, 0, 0, 0)});
    tbl.push_back('{"lbu",   32'h0000C283, pack(0, 2, 1, 1, 0, 2, 0, 3, 1, 0, 0, 0, 0)});
    tbl.push_back('{"lwu",   32'h0000E283, pack(0, 2, 1, 1, 0, 2, 0, 1, 1, 0, 0, 0, 0)});
    tbl.push_back('{"addiw", 32'h0010809B, pack(0, 2, 1, 1, 0, 2, 0, 0, 0, 1, 1, 0, 0)});
    tbl.push_back('{"sltu",  32'h0020B1B3, pack(10, 1, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"ecall", 32'h00000073, pack(0, 2, 1, 1, 0, 2, 0, 0, 2, 0, 0, 1, 0)});
    tbl.push_back('{"divu",  32'h0220D1B3, pack(29, 1, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"srai",  32'h4030D093, pack(13, 2, 1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"badop", 32'h0000007F, pack(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1)});
    tbl.push_back('{"zero",  32'h00000000, pack(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1)});

    // reset state
    repeat (2) @(negedge clk);
    check("rst_count", 64'(count), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_illegal_cnt", 64'(illegal_cnt), 0);
    check("rst_b_in_ready", 64'(in_ready_b), 1);
    rst_n = 1'b1;
    step();

    // decode table: push, inspect head, pop
    n_ill = 0;
    foreach (tbl[i]) begin
      in_valid = 1; in_inst = tbl[i].inst; in_pc = 64'h8000_0000 + 64'(4 * i);
      step();
      in_valid = 0;
      $display("vec %s inst=%h pc=%h ctl=%h", tbl[i].name, tbl[i].inst, out_pc, ctl);
      check({"vec_valid_", tbl[i].name}, 64'(out_valid), 1);
      check({"vec_ctl_", tbl[i].name}, 64'(ctl), 64'(tbl[i].expct));
      check({"vec_pc_", tbl[i].name}, out_pc, 64'h8000_0000 + 64'(4 * i));
      n_ill += int'(tbl[i].expct[0]);
      out_ready = 1;
      step();
      out_ready = 0;
    end
    check("vec_illegal_cnt", 64'(illegal_cnt), 64'(n_ill));
    check("vec_empty", 64'(out_valid), 0);

    // fill to full with a fifth beat held off, then drain in order
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_inst = 32'h00000013; in_pc = 64'h1000 + 64'(i);
      step();
      if (i == 3) begin
        check("full_in_ready", 64'(in_ready), 0);
        check("full_count", 64'(count), 4);
      end
    end
    in_valid = 0;
    check("full_hold_count", 64'(count), 4);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", out_pc, 64'h1000 + 64'(i));
      step();
    end
    out_ready = 0;
    check("drain_empty", 64'(out_valid), 0);

    // offset the pointers, then three wrapping refills
    in_valid = 1; in_pc = 64'h2FFF; step(); in_valid = 0;
    out_ready = 1; step(); out_ready = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        in_valid = 1; in_pc = 64'h3000 + 64'(16 * r + i);
        step();
      end
      in_valid = 0;
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
        check("wrap_pc", out_pc, 64'h3000 + 64'(16 * r + i));
        step();
      end
      out_ready = 0;
      $display("refill %0d drained", r);
    end

    // flush with three queued and a concurrent push
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_pc = 64'h4000 + 64'(i); step();
    end
    check("preflush_count", 64'(count), 3);
    flush = 1; in_valid = 1; in_pc = 64'hDEAD;
    step();
    flush = 0; in_valid = 0;
    check("flush_count", 64'(count), 0);
    check("flush_out_valid", 64'(out_valid), 0);
    in_valid = 1; in_pc = 64'h5000; step(); in_valid = 0;
    check("postflush_pc", out_pc, 64'h5000);
    check("postflush_count", 64'(count), 1);
    check("flush_keeps_illegal_cnt", 64'(illegal_cnt), 64'(n_ill));

    // asynchronous reset between edges with two entries
    in_valid = 1; in_pc = 64'h5004; step(); in_valid = 0;
    check("prerst_count", 64'(count), 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 64'(count), 0);
    check("arst_out_valid", 64'(out_valid), 0);
    check("arst_in_ready", 64'(in_ready), 1);
    check("arst_illegal_cnt", 64'(illegal_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 32-bit, M-disabled variant
    in_valid_b = 1; in_inst_b = 32'h00113023; in_pc_b = 32'h100; step(); in_valid_b = 0;
    check("b_sd_illegal", 64'(illegal_b), 1);
    check("b_sd_mem_wr", 64'(mem_wr_b), 0);
    check("b_sd_branch", 64'(branch_b), 2);
    check("b_sd_extop", 64'(extop_b), 0);
    out_ready_b = 1; step(); out_ready_b = 0;
    check("b_cnt_after_sd", 64'(illegal_cnt_b), 1);
    in_valid_b = 1; in_inst_b = 32'h022081B3; step(); in_valid_b = 0;
    check("b_mul_illegal", 64'(illegal_b), 1);
    check("b_mul_reg_wr", 64'(reg_wr_b), 0);
    out_ready_b = 1; step(); out_ready_b = 0;
    check("b_cnt_after_mul", 64'(illegal_cnt_b), 2);
    in_valid_b = 1; in_inst_b = 32'h0000A283; step(); in_valid_b = 0;
    check("b_lw_ctl", 64'({alu_ct_b, extop_b, reg_wr_b, mem_op_b, illegal_b}), 64'({5'd0, 3'd2, 1'b1, 3'd5, 1'b0}));
    out_ready_b = 1; step(); out_ready_b = 0;
    in_valid_b = 1; in_inst_b = 32'h0010809B; step(); in_valid_b = 0;
    check("b_addiw_illegal", 64'(illegal_b), 1);
    out_ready_b = 1; step(); out_ready_b = 0;
    check("b_cnt_final", 64'(illegal_cnt_b), 3);

    // randomized traffic against the reference queue
    mq.delete();
    m_ill = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit do_push, do_pop;
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 3);
      in_inst   = rand_inst();
      in_pc     = {$urandom, $urandom};
      check("rnd_count", 64'(count), 64'(mq.size()));
      check("rnd_out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("rnd_in_ready", 64'(in_ready), 64'(mq.size() != 4));
      check("rnd_illegal_cnt", 64'(illegal_cnt), 64'(m_ill));
      if (mq.size() != 0) begin
        check("rnd_pc", out_pc, mq[0].pc);
        check("rnd_inst", 64'(out_inst), 64'(mq[0].inst));
        check("rnd_ctl", 64'(ctl), 64'(model_ctl(mq[0].inst, 64, 1)));
      end
      do_push = in_valid && (mq.size() != 4);
      do_pop  = out_ready && (mq.size() != 0);
      if (flush) begin
        mq.delete();
      end else begin
        if (do_pop) begin
          $display("pop pc=%h inst=%h", mq[0].pc, mq[0].inst);
          if (model_ctl(mq[0].inst, 64, 1) & 25'd1) m_ill = (m_ill < 65535) ? m_ill + 1 : m_ill;
          void'(mq.pop_front());
        end
        if (do_push) mq.push_back('{in_inst, in_pc});
      end
      step();
    end
    in_valid = 0; out_ready = 0; flush = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
